// File: rtl/piso_sreg_serializer.sv
// Parallel-in/serial-out shifter with a valid/ready load port and a gapless serial output.
// Optional even-parity trailer bit is enabled by defining PISO_SREG_SERIALIZER_PARITY_EN.
module piso_sreg_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_last,
  output logic             busy
);

`ifdef PISO_SREG_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 so_q, so_d;
  logic                 so_valid_q, so_valid_d;
  logic                 so_last_q, so_last_d;
  logic                 busy_q, busy_d;
  logic                 at_last_s;
  logic                 ready_s;
  logic                 load_s;

`ifdef PISO_SREG_SERIALIZER_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  // The bit to transmit always sits at the top of the shift register, so
  // LSB-first operation is handled by reversing the word once at load time.
  function automatic logic [FRAME_LEN-1:0] frame_of(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] ord;
    for (int i = 0; i < WIDTH; i++) begin
      ord[i] = MSB_FIRST ? w[i] : w[WIDTH-1-i];
    end
`ifdef PISO_SREG_SERIALIZER_PARITY_EN
    return {ord, even_parity(w)};
`else
    return ord;
`endif
  endfunction

  // Handshake, next-state and next-output computation.
  always_comb begin
    at_last_s = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    ready_s   = rst_n && ((state_q == ST_IDLE) || (ce && at_last_s));
    load_s    = ready_s && s_valid;
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (load_s) begin
          state_d = ST_SHIFT;
          shreg_d = frame_of(s_data);
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!ce) begin
          state_d = ST_SHIFT;
        end else if (at_last_s) begin
          if (load_s) begin
            state_d = ST_SHIFT;
            shreg_d = frame_of(s_data);
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = ST_IDLE;
            shreg_d = {FRAME_LEN{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
          end
        end else begin
          shreg_d = {shreg_q[FRAME_LEN-2:0], 1'b0};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        shreg_d = {FRAME_LEN{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    // Outputs are registered views of the next state so they line up with shreg.
    so_valid_d = (state_d == ST_SHIFT);
    busy_d     = (state_d == ST_SHIFT);
    so_d       = (state_d == ST_SHIFT) ? shreg_d[FRAME_LEN-1] : 1'b0;
    so_last_d  = (state_d == ST_SHIFT) && (cnt_d == CNT_LAST);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= {FRAME_LEN{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      so_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      so_last_q  <= so_last_d;
      busy_q     <= busy_d;
    end
  end

  assign s_ready  = ready_s;
  assign so       = so_q;
  assign so_valid = so_valid_q;
  assign so_last  = so_last_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_piso_sreg_serializer.sv
// Self-checking bench for piso_sreg_serializer: scoreboard of expected {bit, last}
// pairs pushed at word acceptance and popped as the DUT emits bits.
module tb_piso_sreg_serializer;
  localparam int W = 8;
`ifdef PISO_SREG_SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ce, s_valid, s_ready, so, so_valid, so_last, busy;
  logic [W-1:0] s_data;
  logic         ce_b, s_valid_b, s_ready_b, so_b, so_valid_b, so_last_b, busy_b;
  logic [W-1:0] s_data_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  piso_sreg_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .so(so), .so_valid(so_valid), .so_last(so_last), .busy(busy)
  );

  piso_sreg_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .ce(ce_b), .s_data(s_data_b), .s_valid(s_valid_b),
    .s_ready(s_ready_b), .so(so_b), .so_valid(so_valid_b), .so_last(so_last_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  function automatic void push_word(input logic [W-1:0] d, input bit msb_first);
    logic b;
    for (int i = 0; i < W; i++) begin
      b = msb_first ? d[W-1-i] : d[i];
      exp_q.push_back({b, (i == FL - 1) ? 1'b1 : 1'b0});
    end
`ifdef PISO_SREG_SERIALIZER_PARITY_EN
    exp_q.push_back({^d, 1'b1});
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    ce_b = 1'b1; s_valid_b = 1'b1; s_data_b = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({s_ready, so, so_valid, so_last, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy,so,vld,last,busy=%b want 00000",
               {s_ready, so, so_valid, so_last, busy});
    end
    n_checks++;
    if ({s_ready_b, so_b, so_valid_b, so_last_b, busy_b} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_lsb: got %b want 00000",
               {s_ready_b, so_b, so_valid_b, so_last_b, busy_b});
    end
    @(posedge clk); #1;
    rst_n = 1'b1; s_valid = 1'b0; s_valid_b = 1'b0;
  endtask

  task automatic test_single_word(input logic [W-1:0] d);
    int nvalid = 0;
    logic [1:0] e;
    exp_q.delete();
    @(posedge clk); #1;
    ce = 1'b1; s_data = d; s_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready_idle(%h): got %b want 1", d, s_ready);
    end
    push_word(d, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = 8'h00;
    for (int i = 0; i < FL + 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_checks++;
        if (so_valid !== 1'b1) begin
          n_fail++; $display("FAIL single_latency(%h): so_valid got %b want 1", d, so_valid);
        end
      end
      if (so_valid === 1'b1) begin
        nvalid++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL single_extra_bit(%h): unexpected bit %0d", d, nvalid);
        end else begin
          e = exp_q.pop_front();
          if ({so, so_last} !== e) begin
            n_fail++;
            $display("FAIL single_bit(%h) #%0d: got so,last=%b want %b", d, nvalid, {so, so_last}, e);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (nvalid != FL || exp_q.size() != 0) begin
      n_fail++; $display("FAIL single_len(%h): got %0d bits want %0d", d, nvalid, FL);
    end
    n_checks++;
    if ({so, so_valid, so_last, busy} !== 4'b0) begin
      n_fail++; $display("FAIL single_idle(%h): got so,vld,last,busy=%b want 0000", d,
                         {so, so_valid, so_last, busy});
    end
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    bit drop = 1'b0;
    logic exp_rdy;
    logic [1:0] e;
    exp_q.delete();
    @(posedge clk); #1;
    ce = 1'b1; s_data = 8'hF0; s_valid = 1'b1;
    push_word(8'hF0, 1'b1);
    @(posedge clk); #1;
    s_data = 8'h0F;
    push_word(8'h0F, 1'b1);
    for (int i = 0; i < 2 * FL + 3; i++) begin
      @(negedge clk);
      exp_rdy = (so_valid !== 1'b1) ? 1'b1 : ((nvalid % FL) == FL - 1);
      n_checks++;
      if (s_ready !== exp_rdy) begin
        n_fail++; $display("FAIL b2b_ready cyc %0d: got %b want %b", i, s_ready, exp_rdy);
      end
      if (so_valid === 1'b1) begin
        if (nvalid == FL - 1) drop = 1'b1;
        nvalid++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_bit: unexpected bit %0d", nvalid);
        end else begin
          e = exp_q.pop_front();
          if ({so, so_last} !== e) begin
            n_fail++; $display("FAIL b2b_bit #%0d: got so,last=%b want %b", nvalid, {so, so_last}, e);
          end
        end
      end else if (nvalid > 0 && nvalid < 2 * FL) begin
        n_checks++; n_fail++;
        $display("FAIL b2b_gap: so_valid low after %0d bits want %0d contiguous", nvalid, 2 * FL);
      end
      @(posedge clk); #1;
      if (drop) s_valid = 1'b0;
    end
    n_checks++;
    if (nvalid != 2 * FL || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_len: got %0d bits want %0d", nvalid, 2 * FL);
    end
  endtask

  task automatic test_ce_toggle();
    int ce_bits = 0;
    logic prev_so = 1'b0, prev_last = 1'b0, prev_vld = 1'b0, prev_ce = 1'b1;
    logic [1:0] e;
    exp_q.delete();
    @(posedge clk); #1;
    ce = 1'b0; s_data = 8'h81; s_valid = 1'b1;
    push_word(8'h81, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    ce = 1'b1;
    for (int i = 0; i < 3 * FL + 6; i++) begin
      @(negedge clk);
      if (prev_vld && !prev_ce) begin
        n_checks++;
        if (so_valid !== 1'b1 || {so, so_last} !== {prev_so, prev_last}) begin
          n_fail++; $display("FAIL ce_hold cyc %0d: got vld,so,last=%b want 1%b", i,
                             {so_valid, so, so_last}, {prev_so, prev_last});
        end
      end
      if (so_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL ce_extra_bit cyc %0d", i);
        end else begin
          e = exp_q[0];
          if ({so, so_last} !== e) begin
            n_fail++; $display("FAIL ce_bit cyc %0d: got so,last=%b want %b", i, {so, so_last}, e);
          end
          if (ce) begin
            void'(exp_q.pop_front());
            ce_bits++;
          end
        end
      end
      prev_so = so; prev_last = so_last; prev_vld = so_valid; prev_ce = ce;
      @(posedge clk); #1;
      ce = ((i + 1) % 3 == 0);
    end
    ce = 1'b1;
    n_checks++;
    if (ce_bits != FL || exp_q.size() != 0 || so_valid !== 1'b0) begin
      n_fail++; $display("FAIL ce_frame_len: got %0d ce bits want %0d (vld=%b)", ce_bits, FL, so_valid);
    end
  endtask

  task automatic test_lsb_first();
    int nvalid = 0;
    logic [1:0] e;
    exp_q.delete();
    @(posedge clk); #1;
    ce_b = 1'b1; s_data_b = 8'h01; s_valid_b = 1'b1;
    push_word(8'h01, 1'b0);
    @(posedge clk); #1;
    s_valid_b = 1'b0;
    for (int i = 0; i < FL + 3; i++) begin
      @(negedge clk);
      if (so_valid_b === 1'b1) begin
        nvalid++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL lsb_extra_bit #%0d", nvalid);
        end else begin
          e = exp_q.pop_front();
          if ({so_b, so_last_b} !== e) begin
            n_fail++; $display("FAIL lsb_bit #%0d: got so,last=%b want %b", nvalid, {so_b, so_last_b}, e);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (nvalid != FL) begin
      n_fail++; $display("FAIL lsb_len: got %0d bits want %0d", nvalid, FL);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0] e;
    exp_q.delete();
    @(posedge clk); #1;
    ce = 1'b1; s_data = 8'hA5; s_valid = 1'b1;
    push_word(8'hA5, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({so_valid, so, so_last} !== {1'b1, e}) begin
        n_fail++; $display("FAIL midrst_bit %0d: got vld,so,last=%b want 1%b", i, {so_valid, so, so_last}, e);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'hFF;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ready: got %b want 0", s_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({so, so_valid, so_last, busy} !== 4'b0) begin
      n_fail++; $display("FAIL midrst_abort: got so,vld,last,busy=%b want 0000", {so, so_valid, so_last, busy});
    end
    rst_n = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({so_valid, busy} !== 2'b0) begin
      n_fail++; $display("FAIL midrst_no_resume: got vld,busy=%b want 00", {so_valid, busy});
    end
    test_single_word(8'h3C);
  endtask

  initial begin
    test_reset();
    test_single_word(8'hA5);
    test_back_to_back();
    test_ce_toggle();
    test_lsb_first();
    test_reset_mid_frame();
    test_single_word(8'h07);
    test_single_word(8'h03);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
